// File: rtl/instr_encoder_pkg.sv
// ---------------------------------------------------------------------------
// instr_encoder_pkg
//   Shared ISA constants for the instruction encoder and decoder: request
//   class codes, the SPECIAL/REGIMM major opcodes, and the branch/jump
//   opcode and func codes that mark control-transfer instructions.
//   No ports; import with instr_encoder_pkg::*.
// ---------------------------------------------------------------------------
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_J      = 3'd2,
    CLS_REGIMM = 3'd3,
    CLS_NOP    = 3'd4
  } instr_class_e;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FUNC_JR    = 6'b001000;
  localparam logic [5:0] FUNC_JALR  = 6'b001001;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  // I-class opcodes that are conditional branches (need a delay slot).
  function automatic logic is_branch_op(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) || (op == OP_BGTZ);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
//   Request channel into the encoder: valid/ready handshake plus the raw
//   instruction fields.
//   master : drives w_req_valid and the fields, samples w_req_ready
//   slave  : the encoder; drives w_req_ready
// ---------------------------------------------------------------------------
interface instr_encoder_if;
  logic        w_req_valid;
  logic        w_req_ready;
  logic [2:0]  w_req_class_3;
  logic [5:0]  w_op_type_6;
  logic [4:0]  w_rs_addr_5;
  logic [4:0]  w_rt_addr_5;
  logic [4:0]  w_rd_addr_5;
  logic [4:0]  w_sh_amt_5;
  logic [25:0] w_imm_val_26;

  modport master (
    output w_req_valid, w_req_class_3, w_op_type_6,
           w_rs_addr_5, w_rt_addr_5, w_rd_addr_5, w_sh_amt_5, w_imm_val_26,
    input  w_req_ready
  );

  modport slave (
    input  w_req_valid, w_req_class_3, w_op_type_6,
           w_rs_addr_5, w_rt_addr_5, w_rd_addr_5, w_sh_amt_5, w_imm_val_26,
    output w_req_ready
  );
endinterface

// File: rtl/instr_pack.sv
// ---------------------------------------------------------------------------
// instr_pack
//   Purely combinational field-to-word packer.
//   Inputs : req_class, op_type, rs/rt/rd, sh_amt, imm
//   Outputs: word      - encoded 32-bit instruction (0 for NOP/illegal)
//            ctrl_xfer - instruction is a jump/branch (wants a delay slot)
//            illegal   - class code 5..7
// ---------------------------------------------------------------------------
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  req_class,
  input  logic [5:0]  op_type,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  sh_amt,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        ctrl_xfer,
  output logic        illegal
);

  always_comb begin
    word      = NOP_WORD;
    ctrl_xfer = 1'b0;
    illegal   = 1'b0;
    case (req_class)
      CLS_R: begin
        word      = {OP_SPECIAL, rs, rt, rd, sh_amt, op_type};
        ctrl_xfer = (op_type == FUNC_JR) || (op_type == FUNC_JALR);
      end
      CLS_I: begin
        word      = {op_type, rs, rt, imm[15:0]};
        ctrl_xfer = is_branch_op(op_type);
      end
      CLS_J: begin
        word      = {op_type, imm};
        ctrl_xfer = 1'b1;
      end
      CLS_REGIMM: begin
        // op_type carries the rt-field branch code in its low five bits.
        word      = {OP_REGIMM, rs, op_type[4:0], imm[15:0]};
        ctrl_xfer = 1'b1;
      end
      CLS_NOP: begin
        word = NOP_WORD;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Accepts instruction field requests, packs them into 32-bit words and
//   streams them into instruction memory at consecutive word addresses,
//   optionally padding a NOP delay slot after control transfers.
//   Ports:
//     clock, reset    - single clock, synchronous active-high reset
//     req             - request channel (instr_encoder_if.slave)
//     w_mem_we        - instruction-memory write strobe
//     w_mem_addr_32   - write byte address (held when w_mem_we is low)
//     w_mem_data_32   - encoded word (held when w_mem_we is low)
//     w_count_32      - words written since reset
//     w_full          - DEPTH words have been written; no further requests
//     w_err           - sticky: an illegal class was seen
// ---------------------------------------------------------------------------
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0100_0000,
  parameter int unsigned DEPTH          = 1024,
  parameter bit          PAD_DELAY_SLOT = 1'b1
) (
  input  logic           clock,
  input  logic           reset,
  instr_encoder_if.slave req,
  output logic           w_mem_we,
  output logic [31:0]    w_mem_addr_32,
  output logic [31:0]    w_mem_data_32,
  output logic [31:0]    w_count_32,
  output logic           w_full,
  output logic           w_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_PAD   = 2'd2;
  localparam logic [1:0] S_FULL  = 2'd3;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [1:0]  state_reg;
  logic [31:0] count_reg;
  logic        pad_pending_reg;

  logic [31:0] packed_word;
  logic        packed_ctrl;
  logic        packed_illegal;
  logic        transfer;
  logic [31:0] count_next;

  instr_pack u_pack (
    .req_class (req.w_req_class_3),
    .op_type   (req.w_op_type_6),
    .rs        (req.w_rs_addr_5),
    .rt        (req.w_rt_addr_5),
    .rd        (req.w_rd_addr_5),
    .sh_amt    (req.w_sh_amt_5),
    .imm       (req.w_imm_val_26),
    .word      (packed_word),
    .ctrl_xfer (packed_ctrl),
    .illegal   (packed_illegal)
  );

  assign w_full          = (count_reg == DEPTH_W);
  assign req.w_req_ready = (state_reg == S_IDLE) && !w_full;
  assign transfer        = req.w_req_valid && req.w_req_ready;
  assign w_count_32      = count_reg;
  // The count advances at the end of each write cycle, so during a write
  // count_reg still names the slot being written.
  assign count_next      = count_reg + 32'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      count_reg       <= 32'd0;
      pad_pending_reg <= 1'b0;
      w_mem_we        <= 1'b0;
      w_mem_addr_32   <= BASE_ADDR;
      w_mem_data_32   <= NOP_WORD;
      w_err           <= 1'b0;
    end else begin
      w_mem_we <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (transfer) begin
            state_reg       <= S_WRITE;
            w_mem_we        <= 1'b1;
            w_mem_addr_32   <= BASE_ADDR + (count_reg << 2);
            w_mem_data_32   <= packed_word;
            pad_pending_reg <= PAD_DELAY_SLOT && packed_ctrl;
            if (packed_illegal) begin
              w_err <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          count_reg <= count_next;
          // Filling the last slot wins over a pending delay-slot pad.
          if (count_next == DEPTH_W) begin
            state_reg <= S_FULL;
          end else if (pad_pending_reg) begin
            state_reg     <= S_PAD;
            w_mem_we      <= 1'b1;
            w_mem_addr_32 <= w_mem_addr_32 + 32'd4;
            w_mem_data_32 <= NOP_WORD;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_PAD: begin
          count_reg <= count_next;
          state_reg <= (count_next == DEPTH_W) ? S_FULL : S_IDLE;
        end
        default: begin
          // S_FULL: terminal until reset.
          state_reg <= S_FULL;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Params: BASE_ADDR, 32'h0100_0000, byte address of first emitted word; DEPTH, 1024, max words emitted; PAD_DELAY_SLOT, 1, auto-emit NOP after control-transfer instructions.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 w_req_valid  input  1  field request present.
REQ-005 w_req_ready  output  1  encoder accepts request this cycle.
REQ-006 w_req_class_3  input  3  0=R (SPECIAL), 1=I, 2=J, 3=REGIMM, 4=NOP; 5-7 illegal.
REQ-007 w_op_type_6  input  6  opcode (I/J), func (R), or {0,rt code} (REGIMM).
REQ-008 w_rs_addr_5 / w_rt_addr_5 / w_rd_addr_5 / w_sh_amt_5  input  5 each  register fields and shift amount.
REQ-009 w_imm_val_26  input  26  immediate; I/REGIMM use [15:0], J uses [25:0].
REQ-010 w_mem_we  output  1  instruction-memory write strobe.
REQ-011 w_mem_addr_32 / w_mem_data_32  output  32 each  write address and encoded word.
REQ-012 w_count_32  output  32  words written since reset; w_full output 1; w_err output 1 (sticky illegal class).

Function
REQ-013 Handshake: transfer when w_req_valid && w_req_ready; inputs sampled only on transfer; w_req_ready high only in IDLE and w_full low.
REQ-014 FSM states IDLE, WRITE, PAD, FULL; IDLE->WRITE on transfer; WRITE->PAD if pad needed, else IDLE, or FULL if count reaches DEPTH; PAD->IDLE, or FULL if count reaches DEPTH; FULL terminal until reset.
REQ-015 Latency: request accepted at edge N -> w_mem_we=1 with its word for exactly the cycle after edge N; pad NOP written the next cycle; throughput one request per 2 cycles (3 if padded).
REQ-016 Encoding R: {6'b000000, rs, rt, rd, shamt, op_type}.
REQ-017 Encoding I: {op_type, rs, rt, imm[15:0]}.
REQ-018 Encoding J: {op_type, imm[25:0]}.
REQ-019 Encoding REGIMM: {6'b000001, rs, op_type[4:0], imm[15:0]}.
REQ-020 Encoding NOP: 32'h0000_0000; illegal class also emits 32'h0 and sets w_err.
REQ-021 Control transfer (pad trigger when PAD_DELAY_SLOT=1): class J; class I with opcode BEQ/BNE/BLEZ/BGTZ; class REGIMM; class R with func JR/JALR.
REQ-022 w_mem_addr_32 = BASE_ADDR + 4*w_count_32 at each write; w_count_32 increments by 1 per write (incl. pads), no wrap.
REQ-023 w_full = (w_count_32 == DEPTH); pad is suppressed if instruction write made count reach DEPTH.
REQ-024 w_mem_we never asserted in IDLE or FULL; outputs w_mem_addr_32/w_mem_data_32 hold last values when w_mem_we low.

Reset
REQ-025 On reset: state IDLE, w_mem_we 0, w_mem_addr_32 BASE_ADDR, w_mem_data_32 0, w_count_32 0, w_full 0, w_err 0, w_req_ready 1 the cycle after reset deasserts.
REQ-026 Reset mid-WRITE or mid-PAD abandons the pending write; w_mem_we is 0 in the cycle following the reset edge; reset dominates a simultaneous request.

Structure
REQ-027 Class codes, SPECIAL/REGIMM opcodes, branch/jump opcode and func codes live in the shared ISA constants include used by the decoder.
REQ-028 Field-to-word packing is one combinational sub-module, instr_pack; FSM, counter and memory port remain in instr_encoder.

Verification
REQ-029 Class I, op 6'b001001, rs 0, rt 8, imm 5 -> one write, data 32'h2408_0005, addr 32'h0100_0000, count 1.
REQ-030 Class R, rs 9, rt 10, rd 8, shamt 0, func 6'b100000 -> data 32'h012A_4020; no pad.
REQ-031 Class J, op 6'b000010, imm 26'h010_0010 -> data 32'h0810_0010 at addr A, then 32'h0 at A+4 next cycle; ready low both cycles.
REQ-032 DEPTH=4, 5 back-to-back requests -> 4 writes, w_full 1, w_req_ready stays 0; BEQ as 4th request writes no pad.
REQ-033 Class 6 request -> data 32'h0, w_err 1 and stays 1 through later legal requests until reset.
REQ-034 Reset asserted in WRITE cycle -> no w_mem_we next cycle, count 0, next write at 32'h0100_0000.
